// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-stage controller.
//   fetch_state_t : controller FSM states
//   INCR_4/INCR_8 : incr_src encodings for the PC adder mux
//   LINE_OFF_HI   : top PC bit of the word offset inside a 16-byte fetch line
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    REDIR = 2'd3
  } fetch_state_t;

  localparam logic INCR_4 = 1'b0;
  localparam logic INCR_8 = 1'b1;

  localparam int unsigned LINE_OFF_HI = 3;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundle between the fetch controller and its environment
// (hazard unit, branch resolver, instruction memory, PC datapath).
//   master : the controller (fetch_ctrl)
//   slave  : everything around it
// Inputs to the controller: pc, stall, redirect, redirect_target, issue_two, imem_ready.
// Outputs: imem_req, pc_en, pc_src, incr_src, target_out, fetch_valid, flush, miss_cycles.
interface fetch_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      pc;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic             issue_two;
  logic             imem_ready;
  logic             imem_req;
  logic             pc_en;
  logic             pc_src;
  logic             incr_src;
  logic [31:0]      target_out;
  logic [1:0]       fetch_valid;
  logic             flush;
  logic [CNT_W-1:0] miss_cycles;

  modport master (
    input  pc, stall, redirect, redirect_target, issue_two, imem_ready,
    output imem_req, pc_en, pc_src, incr_src, target_out, fetch_valid, flush, miss_cycles
  );

  modport slave (
    output pc, stall, redirect, redirect_target, issue_two, imem_ready,
    input  imem_req, pc_en, pc_src, incr_src, target_out, fetch_valid, flush, miss_cycles
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : clock
//   rst   : synchronous active-high clear
//   en    : count this cycle
//   count : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage controller. Each cycle decides whether the PC holds,
// advances by 4/8, or loads a redirect target; tracks instruction-memory misses
// and defers redirects that arrive during a miss until the memory returns.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fetch_if master modport (see fetch_if for signal list)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter bit          DUAL_FETCH = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  fetch_state_t     state_q, state_d;
  logic             pend_q, pend_d;
  logic [31:0]      tgt_q, tgt_d;

  logic             dual;
  logic             miss_en;
  logic             imem_req;
  logic             pc_en;
  logic             pc_src;
  logic             incr_src;
  logic [31:0]      target_out;
  logic [1:0]       fetch_valid;
  logic             flush;
  logic [CNT_W-1:0] miss_count;
  logic             unused_pc_bits;

  // A pair must not straddle a 16-byte line: slot0 in the last word forces single.
  assign dual = DUAL_FETCH && bus.issue_two && (bus.pc[LINE_OFF_HI:2] != 2'b11);
  assign unused_pc_bits = ^{bus.pc[31:LINE_OFF_HI+1], bus.pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    miss_en     = 1'b0;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    incr_src    = INCR_4;
    target_out  = '0;
    fetch_valid = 2'b00;
    flush       = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        imem_req = 1'b1;
        if (bus.redirect) begin
          // Redirect wins over both stall and a miss starting this cycle.
          pc_src     = 1'b1;
          pc_en      = 1'b1;
          target_out = bus.redirect_target;
          flush      = 1'b1;
        end else if (!bus.imem_ready) begin
          state_d = MISS;
        end else if (bus.stall) begin
          fetch_valid = {dual, 1'b1};
        end else begin
          pc_en       = 1'b1;
          incr_src    = dual ? INCR_8 : INCR_4;
          fetch_valid = {dual, 1'b1};
        end
      end

      MISS: begin
        imem_req = 1'b1;
        miss_en  = 1'b1;
        if (bus.redirect) begin
          // Youngest resolved redirect overwrites any earlier pending one.
          flush  = 1'b1;
          pend_d = 1'b1;
          tgt_d  = bus.redirect_target;
        end
        if (bus.imem_ready) begin
          if (pend_d) begin
            // Returned data belongs to the wrong path; drop it.
            state_d = REDIR;
          end else begin
            state_d = RUN;
            if (bus.stall) begin
              fetch_valid = {dual, 1'b1};
            end else begin
              pc_en       = 1'b1;
              incr_src    = dual ? INCR_8 : INCR_4;
              fetch_valid = {dual, 1'b1};
            end
          end
        end
      end

      REDIR: begin
        pc_src     = 1'b1;
        pc_en      = 1'b1;
        flush      = 1'b1;
        target_out = bus.redirect ? bus.redirect_target : tgt_q;
        pend_d     = 1'b0;
        state_d    = RUN;
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    // Outputs are quiet during the reset cycle regardless of current state.
    if (rst) begin
      miss_en     = 1'b0;
      imem_req    = 1'b0;
      pc_en       = 1'b0;
      pc_src      = 1'b0;
      incr_src    = INCR_4;
      target_out  = '0;
      fetch_valid = 2'b00;
      flush       = 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (miss_en),
    .count (miss_count)
  );

  assign bus.imem_req    = imem_req;
  assign bus.pc_en       = pc_en;
  assign bus.pc_src      = pc_src;
  assign bus.incr_src    = incr_src;
  assign bus.target_out  = target_out;
  assign bus.fetch_valid = fetch_valid;
  assign bus.flush       = flush;
  assign bus.miss_cycles = rst ? '0 : miss_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run against a behavioural
// model of the fetch controller. The bench also plays the PC datapath.
module tb_fetch_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam bit          DUAL  = 1'b1;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.CNT_W(CNT_W)) bus ();

  fetch_ctrl #(
    .DUAL_FETCH (DUAL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic             req;
    logic             en;
    logic             src;
    logic             incr;
    logic [31:0]      tgt;
    logic [1:0]       fv;
    logic             flush;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  // Behavioural model: which phase the fetcher is in, and what redirect is owed.
  bit          m_boot = 1'b1;
  bit          m_miss = 1'b0;
  bit          m_redir_due = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_ptgt = '0;
  int          m_cnt = 0;

  function automatic obs_t dut_obs();
    obs_t o;
    o.req   = bus.imem_req;
    o.en    = bus.pc_en;
    o.src   = bus.pc_src;
    o.incr  = bus.incr_src;
    o.tgt   = bus.target_out;
    o.fv    = bus.fetch_valid;
    o.flush = bus.flush;
    o.cnt   = bus.miss_cycles;
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    bit   pair;
    e = '0;
    if (rst || m_boot) return e;
    e.cnt = CNT_W'(m_cnt);
    pair = DUAL && bus.issue_two && ((bus.pc % 16) != 12);
    if (m_redir_due) begin
      e.en    = 1'b1;
      e.src   = 1'b1;
      e.flush = 1'b1;
      e.tgt   = bus.redirect ? bus.redirect_target : m_ptgt;
    end else if (!m_miss) begin
      e.req = 1'b1;
      if (bus.redirect) begin
        e.en    = 1'b1;
        e.src   = 1'b1;
        e.flush = 1'b1;
        e.tgt   = bus.redirect_target;
      end else if (bus.imem_ready) begin
        e.fv = {pair, 1'b1};
        if (!bus.stall) begin
          e.en   = 1'b1;
          e.incr = pair;
        end
      end
    end else begin
      e.req = 1'b1;
      e.flush = bus.redirect;
      if (bus.imem_ready && !m_pend && !bus.redirect) begin
        e.fv = {pair, 1'b1};
        if (!bus.stall) begin
          e.en   = 1'b1;
          e.incr = pair;
        end
      end
    end
    return e;
  endfunction

  // One clock: PC datapath and model take the edge with the current inputs.
  task automatic advance();
    obs_t e;
    e = model_out();
    @(posedge clk);
    if (rst) begin
      m_boot = 1'b1; m_miss = 1'b0; m_redir_due = 1'b0; m_pend = 1'b0;
      m_ptgt = '0; m_cnt = 0;
      bus.pc = '0;
    end else begin
      if (e.en) bus.pc = e.src ? e.tgt : bus.pc + (e.incr ? 32'd8 : 32'd4);
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_redir_due) begin
        m_redir_due = 1'b0;
        m_pend = 1'b0;
      end else if (!m_miss) begin
        if (!bus.redirect && !bus.imem_ready) m_miss = 1'b1;
      end else begin
        if (m_cnt < SAT) m_cnt++;
        if (bus.redirect) begin
          m_pend = 1'b1;
          m_ptgt = bus.redirect_target;
        end
        if (bus.imem_ready) begin
          m_miss = 1'b0;
          m_redir_due = m_pend;
        end
      end
    end
    #1;
  endtask

  task automatic quiet_inputs();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    bus.issue_two = 1'b1; bus.imem_ready = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    quiet_inputs();
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h40;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = dut_obs();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got %h want 0", i, o);
      end
      advance();
    end
    rst = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
    o = dut_obs();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL boot_outputs: got %h want 0", o);
    end
    advance();
  endtask

  task automatic test_steady();
    logic [4:0] got;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = {bus.imem_req, bus.pc_en, bus.incr_src, bus.fetch_valid};
      checks++;
      if (got !== 5'b11111) begin
        errors++;
        $display("FAIL steady_dual pc=%h: got %b want 11111", bus.pc, got);
      end
      advance();
    end
  endtask

  task automatic test_line_boundary();
    logic [3:0] got;
    bus.pc = 32'h0C;
    @(negedge clk);
    got = {bus.pc_en, bus.incr_src, bus.fetch_valid};
    checks++;
    if (got !== 4'b1001) begin
      errors++;
      $display("FAIL line_end_single: got %b want 1001", got);
    end
    advance();
    @(negedge clk);
    got = {bus.pc_en, bus.incr_src, bus.fetch_valid};
    checks++;
    if (bus.pc !== 32'h10 || got !== 4'b1111) begin
      errors++;
      $display("FAIL line_start_dual: pc=%h got %b want pc=10 1111", bus.pc, got);
    end
    advance();
  endtask

  task automatic test_redirect_priority();
    bus.stall = 1'b1; bus.imem_ready = 1'b0;
    bus.redirect = 1'b1; bus.redirect_target = 32'h200;
    @(negedge clk);
    checks++;
    if ({bus.pc_src, bus.pc_en, bus.flush, bus.fetch_valid} !== 5'b11100
        || bus.target_out !== 32'h200) begin
      errors++;
      $display("FAIL redirect_priority: src/en/flush/fv=%b tgt=%h want 11100 200",
               {bus.pc_src, bus.pc_en, bus.flush, bus.fetch_valid}, bus.target_out);
    end
    advance();
    quiet_inputs();
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.pc_en, bus.pc_src} !== 3'b110 || bus.target_out !== 32'h0
        || bus.pc !== 32'h200) begin
      errors++;
      $display("FAIL redirect_stays_run: req/en/src=%b tgt=%h pc=%h want 110 0 200",
               {bus.imem_req, bus.pc_en, bus.pc_src}, bus.target_out, bus.pc);
    end
    advance();
  endtask

  task automatic test_deferred_redirect();
    quiet_inputs();
    rst = 1'b1; advance(); rst = 1'b0; advance();
    bus.imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.pc_en, bus.fetch_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL miss_first_cycle: got %b want 1000",
               {bus.imem_req, bus.pc_en, bus.fetch_valid});
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      bus.redirect = 1'b1;
      bus.redirect_target = (i == 0) ? 32'h80 : 32'h90;
      @(negedge clk);
      checks++;
      if ({bus.imem_req, bus.pc_en, bus.flush, bus.fetch_valid} !== 5'b10100) begin
        errors++;
        $display("FAIL miss_redirect%0d: got %b want 10100", i,
                 {bus.imem_req, bus.pc_en, bus.flush, bus.fetch_valid});
      end
      advance();
    end
    bus.redirect = 1'b0; bus.imem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.pc_en, bus.fetch_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL miss_return_discard: got %b want 1000",
               {bus.imem_req, bus.pc_en, bus.fetch_valid});
    end
    advance();
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.pc_src, bus.pc_en, bus.flush} !== 4'b0111
        || bus.target_out !== 32'h90 || bus.miss_cycles !== 4'd3) begin
      errors++;
      $display("FAIL redir_cycle: req/src/en/flush=%b tgt=%h cnt=%0d want 0111 90 3",
               {bus.imem_req, bus.pc_src, bus.pc_en, bus.flush}, bus.target_out,
               bus.miss_cycles);
    end
    advance();
    @(negedge clk);
    checks++;
    if (bus.pc !== 32'h90 || {bus.imem_req, bus.pc_en, bus.pc_src, bus.fetch_valid} !== 5'b11011) begin
      errors++;
      $display("FAIL after_redir: pc=%h got %b want 90 11011", bus.pc,
               {bus.imem_req, bus.pc_en, bus.pc_src, bus.fetch_valid});
    end
    advance();
  endtask

  task automatic test_saturation();
    int want;
    quiet_inputs();
    rst = 1'b1; advance(); rst = 1'b0; advance();
    bus.imem_ready = 1'b0;
    advance();
    for (int k = 1; k <= 22; k++) begin
      want = (k - 1 > SAT) ? SAT : k - 1;
      @(negedge clk);
      checks++;
      if (int'(bus.miss_cycles) != want) begin
        errors++;
        $display("FAIL miss_count k=%0d: got %0d want %0d", k, bus.miss_cycles, want);
      end
      advance();
    end
    bus.imem_ready = 1'b1;
    advance();
    @(negedge clk);
    checks++;
    if (bus.miss_cycles !== 4'd15) begin
      errors++;
      $display("FAIL miss_count_hold: got %0d want 15", bus.miss_cycles);
    end
    advance();
  endtask

  task automatic test_reset_in_miss();
    obs_t o;
    quiet_inputs();
    rst = 1'b1; advance(); rst = 1'b0; advance();
    bus.imem_ready = 1'b0; advance();
    bus.redirect = 1'b1; bus.redirect_target = 32'h300; advance();
    bus.redirect = 1'b0; bus.imem_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    o = dut_obs();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_in_miss: got %h want 0", o);
    end
    advance();
    rst = 1'b0;
    @(negedge clk);
    o = dut_obs();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL boot_after_miss_reset: got %h want 0", o);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.imem_req, bus.pc_en, bus.pc_src, bus.flush} !== 4'b1100) begin
        errors++;
        $display("FAIL no_redir_after_reset%0d: got %b want 1100", i,
                 {bus.imem_req, bus.pc_en, bus.pc_src, bus.flush});
      end
      advance();
    end
  endtask

  task automatic test_random();
    obs_t o;
    obs_t e;
    for (int i = 0; i < 600; i++) begin
      rst                 = ($urandom_range(0, 63) == 0);
      bus.stall           = ($urandom_range(0, 3) == 0);
      bus.redirect        = ($urandom_range(0, 5) == 0);
      bus.redirect_target = 32'($urandom_range(0, 1023)) << 2;
      bus.issue_two       = ($urandom_range(0, 3) != 0);
      bus.imem_ready      = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      e = model_out();
      o = dut_obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_cyc%0d pc=%h: got %h want %h", i, bus.pc, o, e);
      end
      advance();
    end
  endtask

  initial begin
    bus.pc = '0;
    quiet_inputs();
    test_reset();
    test_steady();
    test_line_boundary();
    test_redirect_priority();
    test_deferred_redirect();
    test_saturation();
    test_reset_in_miss();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller that sequences the PC datapath and the instruction-memory request. It decides each cycle whether the PC holds, advances by 4 or 8 (single or dual fetch), or loads a redirect target. It tracks outstanding instruction-memory misses and defers redirects that arrive during a miss. It sits between the hazard unit, the execute-stage branch resolver, instruction memory, and the PC register/adder datapath, whose pc_en, pc_src and incr_src selects it drives.

## Interface

Parameters:
- DUAL_FETCH, 1: 1 enables +8 pair fetch; 0 forces +4 only.
- CNT_W, 16: width of the miss-cycle performance counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC register value.
- stall  in  1  hazard unit: hold PC and fetched instructions.
- redirect  in  1  execute stage: taken branch/jump this cycle.
- redirect_target  in  32  target address, valid with redirect.
- issue_two  in  1  decode can accept a pair next cycle.
- imem_ready  in  1  instruction memory returns data this cycle (0 = miss in progress).
- imem_req  out  1  fetch request at address pc.
- pc_en  out  1  PC register write enable.
- pc_src  out  1  1 = load target_out, 0 = load incremented PC.
- incr_src  out  1  0 = PC+4, 1 = PC+8.
- target_out  out  32  address for the PC mux when pc_src=1.
- fetch_valid  out  2  bit0 = slot0 valid, bit1 = slot1 (pc+4) valid.
- flush  out  1  kill instructions in fetch/decode.
- miss_cycles  out  CNT_W  saturating count of cycles spent in MISS.

## Operation

- States: BOOT, RUN, MISS, REDIR.
- Reset values:
  - State BOOT.
  - pending_redirect=0, pending_target=0, miss_cycles=0.
  - All outputs 0 during the reset cycle and in BOOT.
- BOOT: lasts one cycle with no request, then goes to RUN.
- RUN: imem_req=1. The first matching condition below applies.
  - redirect: pc_src=1, pc_en=1, target_out=redirect_target, flush=1, fetch_valid=0. Stay RUN, even if stall or !imem_ready.
  - !imem_ready: pc_en=0, fetch_valid=0. Go to MISS.
  - stall: pc_en=0. fetch_valid is held at its dual/single value. Stay RUN.
  - Otherwise: pc_en=1, pc_src=0, incr_src=dual, fetch_valid={dual,1}.
- dual = DUAL_FETCH & issue_two & (pc[3:2] != 2'b11). A pair never crosses a 16-byte line.
- MISS: imem_req=1, pc_en=0, fetch_valid=0. miss_cycles increments each cycle and saturates at all-ones.
  - redirect in MISS: flush=1. Latch pending_redirect=1 and pending_target=redirect_target. A later redirect overwrites the target (youngest resolved wins).
  - imem_ready with pending_redirect=1: the returned data is discarded (fetch_valid=0). Go to REDIR.
  - imem_ready with pending_redirect=0: behaves as a normal RUN cycle (stall and dual rules apply). Go to RUN.
  - A redirect in the same cycle as imem_ready is treated as pending, so the next state is REDIR.
- REDIR: imem_req=0, pc_src=1, pc_en=1, target_out=pending_target, flush=1. Clears pending_redirect. Goes to RUN.
  - A new redirect in REDIR replaces the target this cycle.
- target_out is 0 whenever pc_src=0.

## Timing

- Outputs are combinational from state, registers and inputs. The PC changes on the next edge after pc_en=1.
- Redirect latency:
  - In RUN: the new PC appears 1 cycle after redirect.
  - In MISS: the new PC appears 1 cycle after the REDIR cycle. REDIR follows the imem_ready cycle.
- Miss: the first cycle with imem_ready=0 is a RUN cycle. MISS is entered on the next edge, and miss_cycles counts from that edge.
- rst mid-miss or mid-redirect: the next state is BOOT and the pending redirect is lost. The PC datapath reloads its own reset value.
- stall never blocks a redirect. stall in MISS has no effect until return.

## Structure

- Shared package fetch_pkg holds:
  - fetch_state_t enum (BOOT, RUN, MISS, REDIR).
  - INCR_4=1'b0 and INCR_8=1'b1.
  - LINE_OFF_HI=3, used for the pair-boundary check.
- Sub-module sat_counter (parameter W; ports clk, rst, en, count) implements miss_cycles.
- The FSM next-state and output logic lives in fetch_ctrl.

## Test plan

- Reset then steady fetch:
  - Stimulus: rst for 2 cycles, pc=0x0, issue_two=1, imem_ready=1.
  - Expected: BOOT cycle with imem_req=0, then pc_en=1, incr_src=1, fetch_valid=2'b11 each cycle.
- Line boundary:
  - Stimulus: pc=0x0C, issue_two=1.
  - Expected: incr_src=0, fetch_valid=2'b01. At pc=0x10, incr_src=1.
- Redirect beats stall and miss:
  - Stimulus: RUN, stall=1, imem_ready=0, redirect=1 with target 0x200.
  - Expected: pc_src=1, pc_en=1, target_out=0x200, flush=1. State stays RUN.
- Deferred redirect:
  - Stimulus: 3-cycle miss; redirect to 0x80 in miss cycle 1, then redirect to 0x90 in miss cycle 2.
  - Expected: return cycle has fetch_valid=0. Next cycle is REDIR with target_out=0x90, imem_req=0. miss_cycles=3.
- Counter saturation:
  - Stimulus: CNT_W=4, 20-cycle miss.
  - Expected: miss_cycles=15 and holds.
- Reset during MISS with pending redirect:
  - Expected: next cycle BOOT, all outputs 0, miss_cycles=0. No REDIR cycle ever occurs.
